boxcar_decimating_accumulator: RTL and testbench

//  Consumes the signed fixed-point product stream of the pipelined fractional multiplier (lock-in demodulation path).

---
 rtl/boxcar_decimating_accumulator_pkg.sv | 17 +
 rtl/boxcar_decimating_accumulator_shifter.sv | 47 ++++
 rtl/boxcar_decimating_accumulator.sv | 114 +++++++++++
 tb/tb_boxcar_decimating_accumulator.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/boxcar_decimating_accumulator_pkg.sv
// boxcar_decimating_accumulator_pkg: shared types and helpers for the boxcar decimator
// Contents: FSM state encoding (ST_IDLE, ST_ACCUM), accumulator width calculation,
//           window-exponent clamp helper.
package boxcar_decimating_accumulator_pkg;

    typedef enum logic {ST_IDLE, ST_ACCUM} state_t;

    // The sum of 2^max_log2n samples needs max_log2n guard bits above the sample width.
    function automatic int acc_w(input int in_width, input int max_log2n);
        return in_width + max_log2n;
    endfunction

    function automatic int clamp_log2n(input int value, input int max_log2n);
        return (value > max_log2n) ? max_log2n : value;
    endfunction

endpackage

// File: rtl/boxcar_decimating_accumulator_shifter.sv
// boxcar_decimating_accumulator_shifter: fixed-point rescale and saturate with registered output
// Ports:
//   clk, reset     rising-edge clock, asynchronous active-low reset
//   load           capture the rescaled value of data into the output registers
//   data           signed IN_BITS value with IN_FRAC fractional bits
//   out_data       signed OUT_BITS value with OUT_FRAC fractional bits, held between loads
//   out_saturated  1 when the last loaded value was clipped
module boxcar_decimating_accumulator_shifter #(
    parameter int IN_BITS  = 42,
    parameter int IN_FRAC  = 8,
    parameter int OUT_BITS = 16,
    parameter int OUT_FRAC = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       load,
    input  logic signed [IN_BITS-1:0]  data,
    output logic signed [OUT_BITS-1:0] out_data,
    output logic                       out_saturated
);

    localparam int UP = (OUT_FRAC > IN_FRAC) ? OUT_FRAC - IN_FRAC : 0;
    localparam int DN = (IN_FRAC > OUT_FRAC) ? IN_FRAC - OUT_FRAC : 0;
    localparam int W  = IN_BITS + UP;
    localparam logic signed [W-1:0] HI = {{(W-OUT_BITS+1){1'b0}}, {(OUT_BITS-1){1'b1}}};
    localparam logic signed [W-1:0] LO = ~HI;

    logic signed [W-1:0] scaled;
    logic                hi;
    logic                lo;

    // Widen first so a left shift for extra fractional bits cannot lose the sign.
    assign scaled = (W'(data) <<< UP) >>> DN;
    assign hi     = scaled > HI;
    assign lo     = scaled < LO;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_data      <= '0;
            out_saturated <= 1'b0;
        end else if (load) begin
            out_data      <= hi ? HI[OUT_BITS-1:0] : lo ? LO[OUT_BITS-1:0] : scaled[OUT_BITS-1:0];
            out_saturated <= hi | lo;
        end
    end

endmodule

// File: rtl/boxcar_decimating_accumulator.sv
// boxcar_decimating_accumulator: sums 2^log2_n valid samples, averages, rescales and saturates
// Ports:
//   clk, reset     rising-edge clock, asynchronous active-low reset
//   enable         1 = accumulate, 0 = idle with partial sum discarded
//   restart        pulse: discard the partial window and relatch log2_n
//   log2_n         window exponent, latched at window start, clamped to MAX_LOG2N
//   in_valid       in_data qualifier, no backpressure
//   in_data        signed sample with IN_FRAC fractional bits
//   out_valid      one-cycle pulse per completed window
//   out_data       signed average with OUT_FRAC fractional bits, held until next out_valid
//   out_saturated  valid with out_valid: out_data was clipped
//   busy           1 while accumulating
// Build option: define BOXCAR_ROUND_EN to round half up instead of truncating toward -inf.
module boxcar_decimating_accumulator
    import boxcar_decimating_accumulator_pkg::*;
#(
    parameter int IN_WIDTH     = 32,
    parameter int IN_FRAC      = 8,
    parameter int OUTPUT_WIDTH = 16,
    parameter int OUT_FRAC     = 8,
    parameter int MAX_LOG2N    = 10
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           enable,
    input  logic                           restart,
    input  logic [$clog2(MAX_LOG2N+1)-1:0] log2_n,
    input  logic                           in_valid,
    input  logic signed [IN_WIDTH-1:0]     in_data,
    output logic                           out_valid,
    output logic signed [OUTPUT_WIDTH-1:0] out_data,
    output logic                           out_saturated,
    output logic                           busy
);

    localparam int ACC_W = acc_w(IN_WIDTH, MAX_LOG2N);
    localparam int LW    = $clog2(MAX_LOG2N + 1);

    state_t                  state;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] rounded;
    logic signed [ACC_W-1:0] window_avg;
    logic [MAX_LOG2N-1:0]    cnt;
    logic [LW-1:0]           n;
    logic [LW-1:0]           n_next;
    logic                    last;
    logic                    fire;

    assign n_next = LW'(clamp_log2n(int'(log2_n), MAX_LOG2N));
    assign sum    = acc + ACC_W'(in_data);
    assign last   = cnt == MAX_LOG2N'((32'd1 << n) - 32'd1);
    // Restart and enable drop both beat window completion.
    assign fire   = (state == ST_ACCUM) & enable & ~restart & in_valid & last;

`ifdef BOXCAR_ROUND_EN
    assign rounded = sum + ((n != '0) ? (ACC_W'(1) <<< (n - LW'(1))) : '0);
`else
    assign rounded = sum;
`endif

    // Arithmetic shift floors toward -inf.
    assign window_avg = rounded >>> n;

    boxcar_decimating_accumulator_shifter #(
        .IN_BITS  (ACC_W),
        .IN_FRAC  (IN_FRAC),
        .OUT_BITS (OUTPUT_WIDTH),
        .OUT_FRAC (OUT_FRAC)
    ) u_shifter (
        .clk           (clk),
        .reset         (reset),
        .load          (fire),
        .data          (window_avg),
        .out_data      (out_data),
        .out_saturated (out_saturated)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            acc       <= '0;
            cnt       <= '0;
            n         <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            out_valid <= fire;
            if (state == ST_IDLE) begin
                if (enable) begin
                    state <= ST_ACCUM;
                    busy  <= 1'b1;
                    n     <= n_next;
                    acc   <= '0;
                    cnt   <= '0;
                end
            end else if (!enable) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
                acc   <= '0;
                cnt   <= '0;
            end else if (restart || fire) begin
                // Relatching at the boundary lets the next window start on the very next sample.
                n   <= n_next;
                acc <= '0;
                cnt <= '0;
            end else if (in_valid) begin
                acc <= sum;
                cnt <= cnt + MAX_LOG2N'(1);
            end
        end
    end

endmodule

// File: tb/tb_boxcar_decimating_accumulator.sv
// tb_boxcar_decimating_accumulator: scoreboard bench with a sample-list reference model
module tb_boxcar_decimating_accumulator;

    localparam int IN_WIDTH     = 32;
    localparam int IN_FRAC      = 8;
    localparam int OUTPUT_WIDTH = 16;
    localparam int OUT_FRAC     = 8;
    localparam int MAX_LOG2N    = 10;
    localparam int LW           = $clog2(MAX_LOG2N + 1);

    typedef struct {
        longint data;
        longint sat;
        longint cyc;
    } exp_t;

    logic                           clk = 1'b0;
    logic                           reset = 1'b0;
    logic                           enable = 1'b0;
    logic                           restart = 1'b0;
    logic [LW-1:0]                  log2_n = '0;
    logic                           in_valid = 1'b0;
    logic signed [IN_WIDTH-1:0]     in_data = '0;
    logic                           out_valid;
    logic signed [OUTPUT_WIDTH-1:0] out_data;
    logic                           out_saturated;
    logic                           busy;

    exp_t   q[$];
    longint m_win[$];
    longint cyc = 0;
    int     checks = 0;
    int     errors = 0;
    bit     m_active = 0;
    bit     exp_busy = 0;
    int     m_n = 0;

    boxcar_decimating_accumulator #(
        .IN_WIDTH     (IN_WIDTH),
        .IN_FRAC      (IN_FRAC),
        .OUTPUT_WIDTH (OUTPUT_WIDTH),
        .OUT_FRAC     (OUT_FRAC),
        .MAX_LOG2N    (MAX_LOG2N)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .restart       (restart),
        .log2_n        (log2_n),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_saturated (out_saturated),
        .busy          (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic int clampn(input int v);
        return (v > MAX_LOG2N) ? MAX_LOG2N : v;
    endfunction

    // Average of a completed window, rescaled and clipped to the output range.
    function automatic exp_t window_result(input int n);
        exp_t   e;
        longint s = 0;
        longint hi = (longint'(1) << (OUTPUT_WIDTH - 1)) - 1;
        longint lo = -hi - 1;
        foreach (m_win[i]) s += m_win[i];
`ifdef BOXCAR_ROUND_EN
        if (n > 0) s += longint'(1) << (n - 1);
`endif
        s = s >>> n;
        if (OUT_FRAC >= IN_FRAC) s = s <<< (OUT_FRAC - IN_FRAC);
        else s = s >>> (IN_FRAC - OUT_FRAC);
        e.sat  = (s > hi || s < lo) ? 1 : 0;
        e.data = (s > hi) ? hi : (s < lo) ? lo : s;
        e.cyc  = 0;
        return e;
    endfunction

    task automatic model_step(input bit en, input bit rs, input int ln, input bit v, input longint d);
        exp_t e;
        if (!m_active) begin
            if (en) begin
                m_active = 1;
                m_n = clampn(ln);
                m_win.delete();
            end
        end else if (!en) begin
            m_active = 0;
            m_win.delete();
        end else if (rs) begin
            m_win.delete();
            m_n = clampn(ln);
        end else if (v) begin
            m_win.push_back(d);
            if (m_win.size() == (1 << m_n)) begin
                e = window_result(m_n);
                e.cyc = cyc + 1;
                q.push_back(e);
                m_win.delete();
                m_n = clampn(ln);
            end
        end
        exp_busy = m_active;
    endtask

    task automatic drive(input bit en, input bit rs, input int ln, input bit v, input longint d);
        @(negedge clk);
        enable   = en;
        restart  = rs;
        log2_n   = LW'(ln);
        in_valid = v;
        in_data  = IN_WIDTH'(d);
        model_step(en, rs, ln, v, d);
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) drive(0, 0, 0, 0, 0);
    endtask

    task automatic hold(input int ln, input int k);
        for (int i = 0; i < k; i++) drive(1, 0, ln, 0, 0);
    endtask

    task automatic start(input int ln);
        drive(0, 0, 0, 0, 0);
        drive(1, 0, ln, 0, 0);
    endtask

    task automatic feed(input int ln, input int k, input longint d);
        for (int i = 0; i < k; i++) drive(1, 0, ln, 1, d);
    endtask

    function automatic longint rand_sample();
        return $urandom_range(0, 1) ? longint'($signed($urandom())) : longint'($urandom_range(0, 80000)) - 40000;
    endfunction

    always @(posedge clk) begin : monitor
        exp_t e;
        #1;
        if (reset) begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out_valid: got out_valid=1 expected 0 at cycle %0d", cyc);
                end else begin
                    e = q.pop_front();
                    check("out_cycle", cyc, e.cyc);
                    check("out_data", out_data, e.data);
                    check("out_saturated", out_saturated, e.sat);
                end
            end else if (q.size() > 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                check("out_valid_latency", out_valid, 1);
            end
            check("busy", busy, exp_busy);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_out_data", out_data, 0);
        check("reset_out_saturated", out_saturated, 0);
        check("reset_busy", busy, 0);
        #20;
        @(negedge clk) reset = 1'b1;

        // Four-sample window: (256+512+768+1024)/4 = 640
        start(2);
        feed(2, 1, 256);
        feed(2, 1, 512);
        feed(2, 1, 768);
        feed(2, 1, 1024);
        hold(2, 2);
        check("t1_out_data", out_data, 640);
        check("t1_out_saturated", out_saturated, 0);

        // Eight -3 samples, then seven -3 and one -2; both average to -3
        start(3);
        feed(3, 8, -3);
        hold(3, 2);
        check("t2_uniform", out_data, -3);
        feed(3, 7, -3);
        feed(3, 1, -2);
        hold(3, 2);
        check("t2_mixed", out_data, -3);

        // Pass-through with saturation at both rails
        start(0);
        feed(0, 3, 64'h7FFF_FFFF);
        hold(0, 1);
        check("t3_pos_sat_data", out_data, 32767);
        check("t3_pos_sat_flag", out_saturated, 1);
        feed(0, 2, -64'sd2147483648);
        hold(0, 1);
        check("t3_neg_sat_data", out_data, -32768);
        feed(0, 1, 1280);
        hold(0, 1);
        check("t3_unsat_flag", out_saturated, 0);

        // Restart on the fourth valid kills the window
        start(2);
        feed(2, 3, 7);
        drive(1, 1, 2, 1, 7);
        feed(2, 4, 100);
        hold(2, 2);
        check("t4_out_data", out_data, 100);

        // Enable drop mid-window, re-raise drops the transition sample
        start(2);
        feed(2, 2, 50);
        drive(0, 0, 2, 1, 50);
        drive(1, 0, 2, 1, 999);
        feed(2, 4, 60);
        hold(2, 2);
        check("t5_out_data", out_data, 60);

        // Asynchronous reset mid-window
        feed(2, 2, 300);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("t5_reset_out_data", out_data, 0);
        check("t5_reset_busy", busy, 0);
        check("t5_reset_out_valid", out_valid, 0);
        m_active = 0;
        exp_busy = 0;
        m_win.delete();
        q.delete();
        @(negedge clk);
        reset   = 1'b1;
        enable  = 1'b0;
        restart = 1'b0;
        in_valid = 1'b0;

        // Continuous stream, log2_n changes mid-window and only takes effect at the boundary
        start(1);
        for (int i = 0; i < 16; i++) drive(1, 0, (i < 6) ? 1 : 2, 1, longint'($urandom_range(0, 4000)) - 2000);
        hold(2, 2);

        // Oversized exponent clamps to the maximum window
        start(15);
        for (int i = 0; i < 1024; i++) drive(1, 0, 15, 1, rand_sample());
        hold(15, 2);

        // Random traffic
        start(2);
        for (int i = 0; i < 3000; i++)
            drive($urandom_range(0, 199) != 0, $urandom_range(0, 149) == 0, $urandom_range(0, 4),
                  $urandom_range(0, 3) != 0, rand_sample());
        idle(4);

        check("scoreboard_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
